// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-master SRAM arbiter: default widths, master ids
// and the lock counter width.
package sram_arb_pkg;
  localparam int SRAM_ADDR_W = 16;
  localparam int SRAM_DATA_W = 32;
  localparam int LOCK_CNT_W  = 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin grant with lock override. Purely combinational; the
// history (last_gnt) and lock state live in the arbiter top.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lock_vld,
  input  logic       lock_id,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock_vld && req[lock_id]) begin
      gnt[lock_id] = 1'b1;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // On conflict the master that did not win last time goes first.
        2'b11:   gnt = (last_gnt == M1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port sync SRAM between m0 (CPU) and
// m1 (DMA), with a bounded lock and tagged read return. Optional grant/conflict
// statistics counters are enabled by defining SRAM_ARB_STATS_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_di,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_do,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_di,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_do,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  output logic              sram_EN,
  output logic              sram_WE,
  input  logic [DATA_W-1:0] sram_DO
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]       m0_gnt_cnt,
  output logic [31:0]       m1_gnt_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_INIT = LOCK_CNT_W'(MAX_LOCK - 1);

  logic [1:0]            gnt;
  logic                  any_gnt, win, win_we, win_lock, owner_hit;
  logic                  lock_vld, lock_id, last_gnt, rd_pend, rd_id;
  logic [LOCK_CNT_W-1:0] lock_cnt;

  sram_arb_rr u_rr (
    .req      ({m1_req, m0_req}),
    .lock_vld (lock_vld),
    .lock_id  (lock_id),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign any_gnt   = |gnt;
  assign win       = gnt[1];
  assign owner_hit = lock_vld && gnt[lock_id];

  always_comb begin
    sram_ADDR = '0;
    sram_DI   = '0;
    win_we    = 1'b0;
    win_lock  = 1'b0;
    if (gnt[0]) begin
      sram_ADDR = m0_addr;
      sram_DI   = m0_di;
      win_we    = m0_we;
      win_lock  = m0_lock;
    end else if (gnt[1]) begin
      sram_ADDR = m1_addr;
      sram_DI   = m1_di;
      win_we    = m1_we;
      win_lock  = m1_lock;
    end
  end

  assign sram_EN = any_gnt;
  assign sram_WE = win_we;

  // lock_cnt holds the further owner grants still allowed; the grant that
  // exhausts it releases the lock, so one lock spans MAX_LOCK grants in total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_id  <= M0;
      lock_cnt <= '0;
      last_gnt <= M1;
      rd_pend  <= 1'b0;
      rd_id    <= M0;
    end else begin
      rd_pend <= any_gnt && !win_we;
      if (any_gnt) begin
        rd_id    <= win;
        last_gnt <= win;
      end
      if (owner_hit) begin
        if (!win_lock || lock_cnt <= LOCK_CNT_W'(1))
          lock_vld <= 1'b0;
        else
          lock_cnt <= lock_cnt - 1'b1;
      end else if (any_gnt && win_lock && LOCK_INIT != '0) begin
        lock_vld <= 1'b1;
        lock_id  <= win;
        lock_cnt <= LOCK_INIT;
      end else begin
        lock_vld <= 1'b0;
      end
    end
  end

  // Read return: data is tagged with the master granted one cycle earlier.
  assign m0_rvalid = rd_pend && (rd_id == M0);
  assign m1_rvalid = rd_pend && (rd_id == M1);
  assign m0_do     = m0_rvalid ? sram_DO : '0;
  assign m1_do     = m1_rvalid ? sram_DO : '0;

`ifdef SRAM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_gnt_cnt   <= '0;
      m1_gnt_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      m0_gnt_cnt   <= sat_inc(m0_gnt_cnt, gnt[0]);
      m1_gnt_cnt   <= sat_inc(m1_gnt_cnt, gnt[1]);
      conflict_cnt <= sat_inc(conflict_cnt, m0_req && m1_req);
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, scoreboard of
// expected read returns, and directed grant-pattern sequences.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_di, m1_di;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_do, m1_do;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI, sram_DO;
  logic        sram_EN, sram_WE;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0] m0_gnt_cnt, m1_gnt_cnt, conflict_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } rd_t;
  rd_t         sb_q[$];
  rd_t         mon_e;
  logic [31:0] mem   [0:65535];
  logic [31:0] model [0:65535];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_di(m0_di),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_do(m0_do),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_di(m1_di),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_do(m1_do),
    .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
    .sram_DO(sram_DO)
`ifdef SRAM_ARB_STATS_EN
    , .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  // Behavioural SRAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (sram_EN) begin
      if (sram_WE) mem[sram_ADDR] <= sram_DI;
      else         sram_DO <= mem[sram_ADDR];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: compare returns, then record this cycle's grant.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("rvalid_owner", 32'(mon_e.id ? m1_rvalid : m0_rvalid), 1);
      chk("rvalid_other", 32'(mon_e.id ? m0_rvalid : m1_rvalid), 0);
      chk("rdata",        mon_e.id ? m1_do : m0_do, mon_e.data);
      chk("do_other",     mon_e.id ? m0_do : m1_do, 0);
    end else begin
      chk("rvalid0_idle", 32'(m0_rvalid), 0);
      chk("rvalid1_idle", 32'(m1_rvalid), 0);
    end
    chk("one_gnt",  32'(m0_gnt & m1_gnt), 0);
    chk("gnt0_req", 32'(m0_gnt & ~m0_req), 0);
    chk("gnt1_req", 32'(m1_gnt & ~m1_req), 0);
    chk("sram_en",  32'(sram_EN), 32'(m0_gnt | m1_gnt));
    if (!m0_req && !m1_req) chk("en_noreq", 32'(sram_EN), 0);
    if (m0_gnt) chk("addr_m0", 32'(sram_ADDR), 32'(m0_addr));
    if (m1_gnt) chk("addr_m1", 32'(sram_ADDR), 32'(m1_addr));
    if (!reset && m0_gnt) begin
      if (m0_we) model[m0_addr] = m0_di;
      else       sb_q.push_back('{id: M0, data: model[m0_addr]});
    end
    if (!reset && m1_gnt) begin
      if (m1_we) model[m1_addr] = m1_di;
      else       sb_q.push_back('{id: M1, data: model[m1_addr]});
    end
  end

  task automatic set_m0(input logic req, input logic we, input logic lock,
                        input logic [15:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = a; m0_di = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic lock,
                        input logic [15:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = a; m1_di = d;
  endtask

  task automatic step(input logic e0, input logic e1, input string tag);
    @(negedge clk);
    chk({tag, "_gnt0"}, 32'(m0_gnt), 32'(e0));
    chk({tag, "_gnt1"}, 32'(m1_gnt), 32'(e1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb_q.delete();
    set_m0(0, 0, 0, 16'h0, 32'h0);
    set_m1(0, 0, 0, 16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_m0(0, 0, 0, 16'h0, 32'h0);
    set_m1(0, 0, 0, 16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en",      32'(sram_EN), 0);
    chk("rst_rvalid0", 32'(m0_rvalid), 0);
    chk("rst_rvalid1", 32'(m1_rvalid), 0);
    reset = 1'b0;

    // Single master: write mem[i]=i, then read back.
    for (int i = 0; i < 256; i++) begin
      set_m0(1, 1, 0, 16'(i), 32'(i));
      step(1, 0, "wr");
    end
    for (int i = 0; i < 256; i++) begin
      set_m0(1, 0, 0, 16'(i), 32'h0);
      step(1, 0, "rd");
    end
    set_m0(1, 1, 0, 16'h10, 32'hA);
    step(1, 0, "pre_a");
    set_m0(1, 1, 0, 16'h20, 32'hB);
    step(1, 0, "pre_b");
    set_m0(0, 0, 0, 16'h0, 32'h0);
    step(0, 0, "idle1");

    // Conflict: alternate starting with m0 after reset.
    do_reset();
    set_m0(1, 0, 0, 16'h10, 32'h0);
    set_m1(1, 0, 0, 16'h20, 32'h0);
    for (int k = 0; k < 8; k++) step(k % 2 == 0, k % 2 == 1, "conf");
    set_m0(0, 0, 0, 16'h0, 32'h0);
    set_m1(0, 0, 0, 16'h0, 32'h0);
    step(0, 0, "idle2");

    // Lock: m1 holds for 8 grants, m0 gets one slot, m1 re-locks.
    do_reset();
    set_m0(1, 0, 0, 16'h10, 32'h0);
    set_m1(1, 0, 1, 16'h20, 32'h0);
    for (int k = 0; k < 20; k++) step(k % 9 == 0, k % 9 != 0, "lock");
    set_m0(0, 0, 0, 16'h0, 32'h0);
    set_m1(0, 0, 0, 16'h0, 32'h0);
    step(0, 0, "idle3");

    // Early unlock: m0 read-modify-write of address 5 (holds 5).
    do_reset();
    set_m0(1, 0, 1, 16'h5, 32'h0);
    set_m1(1, 0, 0, 16'h20, 32'h0);
    step(1, 0, "rmw_rd");
    set_m0(1, 1, 0, 16'h5, 32'd6);
    step(1, 0, "rmw_wr");
    set_m0(0, 0, 0, 16'h0, 32'h0);
    step(0, 1, "rmw_m1");
    set_m1(0, 0, 0, 16'h0, 32'h0);
    set_m0(1, 0, 0, 16'h5, 32'h0);
    step(1, 0, "rmw_chk");
    set_m0(0, 0, 0, 16'h0, 32'h0);
    step(0, 0, "idle4");

    // Owner drop: m1 wins in the same cycle m0 releases its request.
    do_reset();
    set_m0(1, 0, 1, 16'h10, 32'h0);
    step(1, 0, "drop_lk");
    set_m0(0, 0, 0, 16'h0, 32'h0);
    set_m1(1, 0, 0, 16'h20, 32'h0);
    step(0, 1, "drop_m1");
    set_m1(0, 0, 0, 16'h0, 32'h0);
    step(0, 0, "drop_idle");
    set_m0(1, 0, 0, 16'h10, 32'h0);
    set_m1(1, 0, 0, 16'h20, 32'h0);
    step(1, 0, "drop_c0");
    step(0, 1, "drop_c1");
    set_m0(0, 0, 0, 16'h0, 32'h0);
    set_m1(0, 0, 0, 16'h0, 32'h0);
    step(0, 0, "idle5");

    // Reset shortly after a granted, locked m1 read edge.
    set_m1(1, 0, 1, 16'h20, 32'h0);
    @(negedge clk);
    chk("mid_gnt1", 32'(m1_gnt), 1);
    @(posedge clk);
    #1;
    chk("mid_rv_pre", 32'(m1_rvalid), 1);
    #1;
    reset = 1'b1;
    sb_q.delete();
    set_m1(0, 0, 0, 16'h0, 32'h0);
    #1;
    chk("mid_rv_rst", 32'(m1_rvalid), 0);
    chk("mid_do_rst", m1_do, 0);
`ifdef SRAM_ARB_STATS_EN
    chk("stat_m0", m0_gnt_cnt, 0);
    chk("stat_m1", m1_gnt_cnt, 0);
    chk("stat_cf", conflict_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    set_m0(1, 0, 0, 16'h10, 32'h0);
    set_m1(1, 0, 1, 16'h20, 32'h0);
    step(1, 0, "post_rst0");
    step(0, 1, "post_rst1");
    set_m0(0, 0, 0, 16'h0, 32'h0);
    set_m1(0, 0, 0, 16'h0, 32'h0);
    step(0, 0, "idle6");
    step(0, 0, "idle7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
